// File: rtl/pc_gen_ras.sv
// Fetch PC generator with fixed-priority redirect selection and a circular
// return-address stack that supplies targets for function returns.
module pc_gen_ras #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INSTR_BYTES  = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             trap_flag,
  input  logic [XLEN-1:0]                  trap_address,
  input  logic                             branch_flag,
  input  logic [XLEN-1:0]                  branch_address,
  input  logic                             jump_flag,
  input  logic [XLEN-1:0]                  jump_address,
  input  logic                             call_flag,
  input  logic                             ret_flag,
  input  logic [XLEN-1:0]                  link_address,
  output logic [XLEN-1:0]                  pc,
  output logic                             pc_valid,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_empty,
  output logic                             ras_full
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);
  localparam logic [CW-1:0]   CNT_MAX    = CW'(RAS_DEPTH);
  localparam logic [PW-1:0]   PTR_MAX    = PW'(RAS_DEPTH - 1);

  logic [XLEN-1:0] r_pc;
  logic            r_pc_valid;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_top;
  logic            r_empty;
  logic            r_full;
  logic [XLEN-1:0] r_ras [RAS_DEPTH];

  logic [XLEN-1:0] w_pc_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic [PW-1:0]   w_top_nxt;
  logic            w_push;
  logic [PW-1:0]   w_push_idx;
  logic [PW-1:0]   w_top_inc;
  logic [PW-1:0]   w_top_dec;
  logic            w_ras_hit;

  // Pointer arithmetic wraps explicitly so non-power-of-2 depths stay in range.
  assign w_top_inc = (r_top == PTR_MAX) ? '0 : r_top + PW'(1);
  assign w_top_dec = (r_top == '0) ? PTR_MAX : r_top - PW'(1);
  assign w_ras_hit = (r_count != '0);

  always_comb begin
    w_pc_nxt    = r_pc;
    w_count_nxt = r_count;
    w_top_nxt   = r_top;
    w_push      = 1'b0;
    w_push_idx  = r_top;
    if (!r_pc_valid) begin
      // First edge after reset only raises pc_valid; RESET_VECTOR is fetched first.
    end else if (trap_flag) begin
      w_pc_nxt    = trap_address & ALIGN_MASK;
      w_count_nxt = '0;
      w_top_nxt   = '0;
    end else if (!enable) begin
    end else if (branch_flag) begin
      w_pc_nxt = branch_address & ALIGN_MASK;
    end else if (jump_flag) begin
      if (ret_flag && w_ras_hit) begin
        w_pc_nxt = r_ras[r_top] & ALIGN_MASK;
        if (call_flag) begin
          // Pop and push cancel: the link replaces the popped slot in place.
          w_push = 1'b1;
        end else begin
          w_top_nxt   = w_top_dec;
          w_count_nxt = r_count - CW'(1);
        end
      end else begin
        w_pc_nxt = jump_address & ALIGN_MASK;
        if (call_flag) begin
          w_push      = 1'b1;
          w_push_idx  = w_top_inc;
          w_top_nxt   = w_top_inc;
          w_count_nxt = (r_count == CNT_MAX) ? CNT_MAX : r_count + CW'(1);
        end
      end
    end else begin
      w_pc_nxt = r_pc + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc       <= RESET_VECTOR;
      r_pc_valid <= 1'b0;
      r_count    <= '0;
      r_top      <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
    end else begin
      r_pc_valid <= 1'b1;
      r_pc       <= w_pc_nxt;
      r_count    <= w_count_nxt;
      r_top      <= w_top_nxt;
      r_empty    <= (w_count_nxt == '0);
      r_full     <= (w_count_nxt == CNT_MAX);
      if (w_push) r_ras[w_push_idx] <= link_address;
    end
  end

  assign pc        = r_pc;
  assign pc_valid  = r_pc_valid;
  assign ras_count = r_count;
  assign ras_empty = r_empty;
  assign ras_full  = r_full;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed bench for pc_gen_ras: reset/start-up, a vector table of redirects,
// RAS push/pop/overflow, stalls and wrap, then an asynchronous mid-run reset.
module tb_pc_gen_ras;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        trap_flag, branch_flag, jump_flag, call_flag, ret_flag;
  logic [31:0] trap_address, branch_address, jump_address, link_address;
  logic [31:0] pc;
  logic        pc_valid;
  logic [2:0]  ras_count;
  logic        ras_empty, ras_full;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_gen_ras dut (
    .clk(clk), .reset(reset), .enable(enable),
    .trap_flag(trap_flag), .trap_address(trap_address),
    .branch_flag(branch_flag), .branch_address(branch_address),
    .jump_flag(jump_flag), .jump_address(jump_address),
    .call_flag(call_flag), .ret_flag(ret_flag), .link_address(link_address),
    .pc(pc), .pc_valid(pc_valid), .ras_count(ras_count),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  typedef struct {
    string       name;
    logic        en, tr, br, jp, ca, rt;
    logic [31:0] ta, ba, ja, la;
    logic [31:0] exp_pc;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string nm, input logic en, tr, br, jp, ca, rt,
                     input logic [31:0] ta, ba, ja, la, epc, input logic [2:0] ecnt);
    vec_t v;
    v.name = nm; v.en = en; v.tr = tr; v.br = br; v.jp = jp; v.ca = ca; v.rt = rt;
    v.ta = ta; v.ba = ba; v.ja = ja; v.la = la; v.exp_pc = epc; v.exp_cnt = ecnt;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] epc, input logic ev,
                     input logic [2:0] ecnt);
    logic ee, ef;
    ee = (ecnt == 3'd0);
    ef = (ecnt == 3'd4);
    n_vec++;
    if (pc !== epc || pc_valid !== ev || ras_count !== ecnt ||
        ras_empty !== ee || ras_full !== ef) begin
      n_err++;
      $display("FAIL %s: got pc=%h valid=%b cnt=%0d empty=%b full=%b, want pc=%h valid=%b cnt=%0d empty=%b full=%b",
               nm, pc, pc_valid, ras_count, ras_empty, ras_full, epc, ev, ecnt, ee, ef);
    end
  endtask

  task automatic idle_inputs();
    enable = 1'b1; trap_flag = 1'b0; branch_flag = 1'b0; jump_flag = 1'b0;
    call_flag = 1'b0; ret_flag = 1'b0;
    trap_address = '0; branch_address = '0; jump_address = '0; link_address = '0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();

    // Sequential, redirect priority and alignment
    add("trap_over_all", 1,1,1,1,0,0, 32'h100, 32'h40, 32'h80, 0, 32'h100, 0);
    add("trap_stalled",  0,1,0,0,0,0, 32'h204, 0, 0, 0,        32'h204, 0);
    add("br_over_jmp",   1,0,1,1,0,0, 0, 32'h40, 32'h80, 0,    32'h40, 0);
    add("br_align",      1,0,1,0,0,0, 0, 32'h43, 0, 0,         32'h40, 0);
    add("seq_after_br",  1,0,0,0,0,0, 0, 0, 0, 0,              32'h44, 0);
    add("jmp_align",     1,0,0,1,0,0, 0, 0, 32'h82, 0,         32'h80, 0);
    // Five calls overflow the 4-entry stack, dropping 0x10
    add("call1", 1,0,0,1,1,0, 0, 0, 32'h1000, 32'h10, 32'h1000, 1);
    add("call2", 1,0,0,1,1,0, 0, 0, 32'h1000, 32'h20, 32'h1000, 2);
    add("call3", 1,0,0,1,1,0, 0, 0, 32'h1000, 32'h30, 32'h1000, 3);
    add("call4", 1,0,0,1,1,0, 0, 0, 32'h1000, 32'h40, 32'h1000, 4);
    add("call5", 1,0,0,1,1,0, 0, 0, 32'h1000, 32'h50, 32'h1000, 4);
    add("ret1",  1,0,0,1,0,1, 0, 0, 32'h2000, 0, 32'h50, 3);
    add("ret2",  1,0,0,1,0,1, 0, 0, 32'h2000, 0, 32'h40, 2);
    add("ret3",  1,0,0,1,0,1, 0, 0, 32'h2000, 0, 32'h30, 1);
    add("ret4",  1,0,0,1,0,1, 0, 0, 32'h2000, 0, 32'h20, 0);
    add("ret5_empty", 1,0,0,1,0,1, 0, 0, 32'h99C, 0, 32'h99C, 0);
    // Stalls ignore qualified calls
    for (int i = 0; i < 3; i++)
      add("stall_call", 0,0,0,1,1,0, 0, 0, 32'h3000, 32'h70, 32'h99C, 0);
    add("trap_top",   1,1,0,0,0,0, 32'hFFFFFFFC, 0, 0, 0, 32'hFFFFFFFC, 0);
    add("seq_wrap",   1,0,0,0,0,0, 0, 0, 0, 0, 32'h0, 0);
    // Simultaneous call+ret on a non-empty and an empty stack
    add("call_20",    1,0,0,1,1,0, 0, 0, 32'h500, 32'h20, 32'h500, 1);
    add("callret",    1,0,0,1,1,1, 0, 0, 32'h600, 32'h60, 32'h20, 1);
    add("ret_60",     1,0,0,1,0,1, 0, 0, 32'h700, 0, 32'h60, 0);
    add("callret_emp",1,0,0,1,1,1, 0, 0, 32'h800, 32'h90, 32'h800, 1);
    add("ret_90",     1,0,0,1,0,1, 0, 0, 32'h900, 0, 32'h90, 0);
    // Trap flushes the stack; branch ignores call
    add("call_a0",    1,0,0,1,1,0, 0, 0, 32'hB0, 32'hA0, 32'hB0, 1);
    add("trap_flush", 1,1,0,1,1,0, 32'h10, 0, 0, 32'hC0, 32'h10, 0);
    add("ret_flushed",1,0,0,1,0,1, 0, 0, 32'h124, 0, 32'h124, 0);
    add("br_no_call", 1,0,1,1,1,0, 0, 32'h200, 32'h300, 32'h44, 32'h200, 0);
    add("ret_none",   1,0,0,1,0,1, 0, 0, 32'h400, 0, 32'h400, 0);

    // Reset held for three edges, then start-up sequence
    repeat (3) begin
      @(posedge clk); #1;
      chk("in_reset", 32'h0, 1'b0, 3'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("startup_seq", 32'(i * 4), 1'b1, 3'd0);
    end

    foreach (vq[i]) begin
      enable = vq[i].en; trap_flag = vq[i].tr; branch_flag = vq[i].br;
      jump_flag = vq[i].jp; call_flag = vq[i].ca; ret_flag = vq[i].rt;
      trap_address = vq[i].ta; branch_address = vq[i].ba;
      jump_address = vq[i].ja; link_address = vq[i].la;
      @(posedge clk); #1;
      chk(vq[i].name, vq[i].exp_pc, 1'b1, vq[i].exp_cnt);
    end

    // Asynchronous reset in the middle of a cycle
    idle_inputs();
    jump_flag = 1'b1; call_flag = 1'b1; jump_address = 32'h840; link_address = 32'h88;
    @(posedge clk); #1;
    chk("pre_reset_call", 32'h840, 1'b1, 3'd1);
    idle_inputs();
    #2 reset = 1'b0;
    #1 chk("async_reset", 32'h0, 1'b0, 3'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("restart", 32'h0, 1'b1, 3'd0);
    @(posedge clk); #1;
    chk("restart_seq", 32'h4, 1'b1, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
